// File: rtl/reset_teardown.sv
// Ordered teardown/restart sequencer: resets domains 2,1,0 in turn, acks, then releases 0,1,2.
// Latency: hold_rst(n-1) rises DELAYn+2 cycles after hold_rst_n when idle is already high.
// Backpressure: none; req is a level sampled only in RUN and DOWN, idle_n only in its own Qn.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req                    1 = teardown requested, 0 = run requested
//   idle0..idle2           domain n quiesced (synchronous to clk)
//   hold_rst0..hold_rst2   active-high reset to domain n (ORed downstream with power-on reset)
//   ack                    high only while every domain is held (DOWN)
//   timeout_flag[n]        sticky: domain n was forced into reset without reporting idle
//   stage                  current state code
module reset_teardown #(
    parameter int DELAY0  = 10,
    parameter int DELAY1  = 10,
    parameter int DELAY2  = 10,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       idle0,
    input  logic       idle1,
    input  logic       idle2,
    output logic       hold_rst0,
    output logic       hold_rst1,
    output logic       hold_rst2,
    output logic       ack,
    output logic [2:0] timeout_flag,
    output logic [3:0] stage
);

    typedef enum logic [3:0] {
        RUN  = 4'd0,
        Q2   = 4'd1,
        H2   = 4'd2,
        Q1   = 4'd3,
        H1   = 4'd4,
        Q0   = 4'd5,
        H0   = 4'd6,
        DOWN = 4'd7,
        R0   = 4'd8,
        R1   = 4'd9,
        R2   = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] D0      = CNT_W'(DELAY0);
    localparam logic [CNT_W-1:0] D1      = CNT_W'(DELAY1);
    localparam logic [CNT_W-1:0] D2      = CNT_W'(DELAY2);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // The state register is the stage output itself, so stage is registered.
    assign stage = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            hold_rst0    <= 1'b0;
            hold_rst1    <= 1'b0;
            hold_rst2    <= 1'b0;
            ack          <= 1'b0;
            timeout_flag <= 3'b000;
        end else begin
            case (state)
                RUN: begin
                    if (req) begin
                        state        <= Q2;
                        cnt          <= '0;
                        timeout_flag <= 3'b000;
                    end
                end
                // Quiesce waits: idle wins over a timeout landing on the same edge.
                Q2: begin
                    if (idle2 || (cnt == TO_LAST)) begin
                        hold_rst2 <= 1'b1;
                        cnt       <= '0;
                        state     <= H2;
                        if (!idle2) timeout_flag[2] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                Q1: begin
                    if (idle1 || (cnt == TO_LAST)) begin
                        hold_rst1 <= 1'b1;
                        cnt       <= '0;
                        state     <= H1;
                        if (!idle1) timeout_flag[1] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                Q0: begin
                    if (idle0 || (cnt == TO_LAST)) begin
                        hold_rst0 <= 1'b1;
                        cnt       <= '0;
                        state     <= H0;
                        if (!idle0) timeout_flag[0] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Hold states: let the reset settle for DELAYn+1 cycles before moving on.
                H2: begin
                    if (cnt == D2) begin
                        cnt   <= '0;
                        state <= Q1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                H1: begin
                    if (cnt == D1) begin
                        cnt   <= '0;
                        state <= Q0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                H0: begin
                    if (cnt == D0) begin
                        cnt   <= '0;
                        state <= DOWN;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (!req) begin
                        hold_rst0 <= 1'b0;
                        ack       <= 1'b0;
                        cnt       <= '0;
                        state     <= R0;
                    end
                end
                // Release in forward order; a domain is freed only after its predecessor.
                R0: begin
                    if (cnt == D0) begin
                        hold_rst1 <= 1'b0;
                        cnt       <= '0;
                        state     <= R1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R1: begin
                    if (cnt == D1) begin
                        hold_rst2 <= 1'b0;
                        cnt       <= '0;
                        state     <= R2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R2: begin
                    if (cnt == D2) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Unused codes recover to RUN without touching the outputs.
                default: state <= RUN;
            endcase
        end
    end

endmodule
